// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the dual-issue pipeline hazard controller: FSM
// encodings, default multicycle latency and pipeline-register indices.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MD_BUSY  = 3'd1,
    ST_MEM_WAIT = 3'd2
  } state_t;

  localparam int MD_LAT_DEF = 8;
  localparam int CNT_W_DEF  = 5;

  // Bit positions inside the per-register stall/flush vectors.
  localparam int IF_ID      = 0;
  localparam int ID_EX      = 1;
  localparam int EX_MEM     = 2;
  localparam int MEM_WB     = 3;
  localparam int NUM_STAGES = 4;

endpackage

// File: rtl/pipe_md_counter.sv
// Load / decrement / zero-detect down-counter for fixed-latency units.
// clr aborts a countdown; decrement never wraps below zero.
module pipe_md_counter
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the dual-issue 5-stage pipeline.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_use_haz,
  input  logic        md_start,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        br_mispred,
  input  logic        br_slot0,
  input  logic        exc_valid,
  output logic        stall_if_id,
  output logic        stall_id_ex,
  output logic        stall_ex_mem,
  output logic        stall_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        flush_ex_mem,
  output logic        flush_mem_wb,
  output logic        isel_ex_mem,
  output logic        pc_hold,
  output logic        redirect,
  output logic [2:0]  state_o
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  if (MD_LAT < 2 || MD_LAT > 32 || (1 << CNT_W) < MD_LAT) begin : g_bad_param
    $error("pipe_hazard_ctrl: MD_LAT must be 2..32 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_STAGES-1:0]   stall;
  logic [NUM_STAGES-1:0]   flush;
  logic                    isel;
  logic                    hold;
  logic                    redir;
  logic                    cnt_load;
  logic                    cnt_dec;
  logic                    cnt_clr;
  logic                    cnt_zero;
  logic                    mem_stall;
  logic                    md_active;

  pipe_md_counter #(
    .CNT_W (CNT_W)
  ) u_md_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (MD_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // In MEM_WAIT only mem_ready matters; the request is known outstanding.
  assign mem_stall = (state == ST_MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
  // MD_BUSY with an expired count behaves like RUN for the remaining sources.
  assign md_active = (state == ST_MD_BUSY) && !cnt_zero;

  always_comb begin
    stall     = '0;
    flush     = '0;
    isel      = 1'b0;
    hold      = 1'b0;
    redir     = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;
    state_nxt = state;
    if (rst) begin
      state_nxt = ST_RUN;
    end else if (mem_stall) begin
      // A memory wait during a multicycle op freezes the countdown rather
      // than abandoning it, so the FSM stays in MD_BUSY.
      stall     = '1;
      hold      = 1'b1;
      state_nxt = md_active ? ST_MD_BUSY : ST_MEM_WAIT;
    end else if (exc_valid) begin
      flush     = '1;
      redir     = 1'b1;
      cnt_clr   = 1'b1;
      state_nxt = ST_RUN;
    end else if (br_mispred) begin
      flush[IF_ID]  = 1'b1;
      flush[ID_EX]  = 1'b1;
      flush[EX_MEM] = br_slot0;
      isel          = br_slot0;
      redir         = 1'b1;
      cnt_clr       = 1'b1;
      state_nxt     = ST_RUN;
    end else if (md_active) begin
      stall[IF_ID]  = 1'b1;
      stall[ID_EX]  = 1'b1;
      stall[EX_MEM] = 1'b1;
      flush[MEM_WB] = 1'b1;
      hold          = 1'b1;
      cnt_dec       = 1'b1;
      state_nxt     = ST_MD_BUSY;
    end else if (md_start) begin
      // The load-use bubble, if any, is covered by the coming MD_BUSY stall.
      cnt_load  = 1'b1;
      state_nxt = ST_MD_BUSY;
    end else begin
      if (ld_use_haz) begin
        stall[IF_ID] = 1'b1;
        flush[ID_EX] = 1'b1;
        hold         = 1'b1;
      end
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  assign stall_if_id  = stall[IF_ID];
  assign stall_id_ex  = stall[ID_EX];
  assign stall_ex_mem = stall[EX_MEM];
  assign stall_mem_wb = stall[MEM_WB];
  assign flush_if_id  = flush[IF_ID];
  assign flush_id_ex  = flush[ID_EX];
  assign flush_ex_mem = flush[EX_MEM];
  assign flush_mem_wb = flush[MEM_WB];
  assign isel_ex_mem  = isel;
  assign pc_hold      = hold;
  assign redirect     = redir;
  assign state_o      = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hold) begin
        perf_stall_cyc <= sat_inc(perf_stall_cyc);
      end
      if (redir) begin
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (default build, MD_LAT=8).
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_use_haz = 1'b0;
  logic       md_start = 1'b0;
  logic       mem_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic       br_mispred = 1'b0;
  logic       br_slot0 = 1'b0;
  logic       exc_valid = 1'b0;
  logic       stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
  logic       flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic       isel_ex_mem, pc_hold, redirect;
  logic [2:0] state_o;

  int checks = 0;
  int failures = 0;

  // Input vector bits: {ld_use_haz, md_start, mem_req, mem_ready, br_mispred, br_slot0, exc_valid}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_LD   = 7'b1000000;
  localparam logic [6:0] I_MD   = 7'b0100000;
  localparam logic [6:0] I_MREQ = 7'b0010000;
  localparam logic [6:0] I_MRDY = 7'b0001000;
  localparam logic [6:0] I_BR   = 7'b0000100;
  localparam logic [6:0] I_S0   = 7'b0000010;
  localparam logic [6:0] I_EXC  = 7'b0000001;

  // Output vector: {stall x4 (IF/ID..MEM/WB), flush x4, isel, pc_hold, redirect}
  localparam logic [10:0] O_NONE = 11'b0000_0000_0_0_0;
  localparam logic [10:0] O_MEMW = 11'b1111_0000_0_1_0;
  localparam logic [10:0] O_MDB  = 11'b1110_0001_0_1_0;
  localparam logic [10:0] O_EXC  = 11'b0000_1111_0_0_1;
  localparam logic [10:0] O_BR1  = 11'b0000_1110_1_0_1;
  localparam logic [10:0] O_BR0  = 11'b0000_1100_0_0_1;
  localparam logic [10:0] O_LDU  = 11'b1000_0100_0_1_0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ld_use_haz   (ld_use_haz),
    .md_start     (md_start),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .br_mispred   (br_mispred),
    .br_slot0     (br_slot0),
    .exc_valid    (exc_valid),
    .stall_if_id  (stall_if_id),
    .stall_id_ex  (stall_id_ex),
    .stall_ex_mem (stall_ex_mem),
    .stall_mem_wb (stall_mem_wb),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .flush_mem_wb (flush_mem_wb),
    .isel_ex_mem  (isel_ex_mem),
    .pc_hold      (pc_hold),
    .redirect     (redirect),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb,
            isel_ex_mem, pc_hold, redirect};
  endfunction

  // Drive one cycle's inputs just after the falling edge; outputs settle by #1.
  task automatic apply(input logic r, input logic [6:0] v);
    @(negedge clk);
    rst = r;
    {ld_use_haz, md_start, mem_req, mem_ready, br_mispred, br_slot0, exc_valid} = v;
    #1;
  endtask

  initial begin
    // Reset state
    apply(1'b1, I_NONE); chk("rst_outs0", 32'(outs()), 32'(O_NONE));
    apply(1'b1, I_NONE); chk("rst_outs1", 32'(outs()), 32'(O_NONE));
    chk("rst_state", 32'(state_o), 32'd0);

    // Reset held 3 cycles mid-MD_BUSY (counter = 5)
    apply(1'b0, I_MD);   chk("rmd_start", 32'(outs()), 32'(O_NONE));
    apply(1'b0, I_NONE); chk("rmd_c7", 32'(outs()), 32'(O_MDB));
    chk("rmd_st", 32'(state_o), 32'd1);
    apply(1'b0, I_NONE); chk("rmd_c6", 32'(outs()), 32'(O_MDB));
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, I_NONE); chk("rmd_inrst", 32'(outs()), 32'(O_NONE));
    end
    apply(1'b0, I_NONE); chk("rmd_post_st", 32'(state_o), 32'd0);
    chk("rmd_post_o", 32'(outs()), 32'(O_NONE));
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, I_NONE); chk("rmd_quiet", 32'(outs()), 32'(O_NONE));
    end

    // md_start: 7 stall cycles, unstalled on cycle 8, RUN after
    apply(1'b0, I_MD); chk("md_c0", 32'(outs()), 32'(O_NONE));
    for (int i = 1; i <= 7; i++) begin
      apply(1'b0, I_NONE);
      chk("md_stall", 32'(outs()), 32'(O_MDB));
      chk("md_state", 32'(state_o), 32'd1);
    end
    apply(1'b0, I_NONE); chk("md_c8", 32'(outs()), 32'(O_NONE));
    apply(1'b0, I_NONE); chk("md_c9_st", 32'(state_o), 32'd0);
    chk("md_c9_o", 32'(outs()), 32'(O_NONE));

    // Memory wait: 4 stalled cycles, cycle 5 released
    for (int i = 1; i <= 4; i++) begin
      apply(1'b0, I_MREQ);
      chk("mw_stall", 32'(outs()), 32'(O_MEMW));
      chk("mw_state", 32'(state_o), (i == 1) ? 32'd0 : 32'd2);
    end
    apply(1'b0, I_MREQ | I_MRDY); chk("mw_release", 32'(outs()), 32'(O_NONE));
    apply(1'b0, I_NONE); chk("mw_run", 32'(state_o), 32'd0);

    // Mispredict, both slots
    apply(1'b0, I_BR | I_S0); chk("br_slot0", 32'(outs()), 32'(O_BR1));
    apply(1'b0, I_BR);        chk("br_slot1", 32'(outs()), 32'(O_BR0));
    apply(1'b0, I_NONE);      chk("br_after", 32'(state_o), 32'd0);

    // Load-use vs mispredict, then load-use alone
    apply(1'b0, I_LD | I_BR); chk("ldbr", 32'(outs()), 32'(O_BR0));
    chk("ldbr_nostall", 32'(stall_if_id), 32'd0);
    apply(1'b0, I_LD);   chk("ldu", 32'(outs()), 32'(O_LDU));
    apply(1'b0, I_NONE); chk("ldu_once", 32'(outs()), 32'(O_NONE));

    // md_start with mispredict: md cancelled
    apply(1'b0, I_MD | I_BR); chk("mdbr", 32'(outs()), 32'(O_BR0));
    apply(1'b0, I_NONE); chk("mdbr_st", 32'(state_o), 32'd0);
    chk("mdbr_o", 32'(outs()), 32'(O_NONE));

    // md_start with load-use, then exception at counter = 3
    apply(1'b0, I_MD | I_LD); chk("mdld", 32'(outs()), 32'(O_NONE));
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, I_NONE); chk("mdld_stall", 32'(outs()), 32'(O_MDB));
    end
    apply(1'b0, I_EXC); chk("exc_md", 32'(outs()), 32'(O_EXC));
    chk("exc_md_st", 32'(state_o), 32'd1);
    apply(1'b0, I_NONE); chk("exc_post_st", 32'(state_o), 32'd0);
    chk("exc_post_o", 32'(outs()), 32'(O_NONE));
    apply(1'b0, I_NONE); chk("exc_cnt0", 32'(outs()), 32'(O_NONE));

    // Exception in RUN; exception masked by a memory wait
    apply(1'b0, I_EXC | I_BR | I_S0); chk("exc_run", 32'(outs()), 32'(O_EXC));
    apply(1'b0, I_MREQ | I_EXC);      chk("exc_memw", 32'(outs()), 32'(O_MEMW));
    apply(1'b0, I_EXC | I_MRDY);      chk("exc_memrel", 32'(outs()), 32'(O_EXC));
    apply(1'b0, I_NONE);              chk("end_st", 32'(state_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard/sequencing controller for the dual-issue 5-stage pipeline.
- Drives the Stall, Flush and issue_select inputs of the four inter-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sources it arbitrates: load-use hazards, a fixed-latency multicycle unit (mul/div), data-memory wait handshakes, branch mispredicts and exceptions.
- Also produces the PC hold and redirect strobes for fetch.

Parameters:
- MD_LAT, 8: multicycle-unit latency in cycles, valid range 2..32.
- CNT_W, 5: width of the multicycle down-counter; must satisfy 2^CNT_W >= MD_LAT.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  synchronous reset, active-high.
- ld_use_haz  in  1  instruction in ID needs the result of a load currently in EX.
- md_start  in  1  multicycle op entering EX this cycle; single-cycle pulse.
- mem_req  in  1  MEM stage has an outstanding data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- br_mispred  in  1  branch in EX resolved mispredicted.
- br_slot0  in  1  mispredicted branch sits in issue slot 0, so slot 1 of the same bundle is younger.
- exc_valid  in  1  exception or trap taken at MEM.
- stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb  out  1 each  Stall to each pipeline register.
- flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  Flush to each pipeline register.
- isel_ex_mem  out  1  issue_select to EX/MEM; partial (slot-1-only) flush.
- pc_hold  out  1  fetch holds the PC.
- redirect  out  1  fetch loads the target PC.
- state_o  out  3  current FSM state, for debug.

Behaviour:
- Reset:
  - While rst=1 on a clock edge: FSM goes to RUN, md counter clears to 0.
  - All stall, flush, isel, pc_hold and redirect outputs are 0.
  - Reset mid-multicycle or mid-memory-wait abandons that operation with no residual stall.
- Outputs are combinational from (state, counter, inputs) and are consumed at the same edge.
- Implementation note: a pipeline register with Stall=1 ignores Flush, so this block never asserts stall and flush on the same register.
- FSM states: RUN, MD_BUSY, MEM_WAIT.
- MEM_WAIT:
  - Entered when mem_req=1 and mem_ready=0.
  - All four registers stall and pc_hold=1.
  - Exits to RUN on the first cycle mem_ready=1; that cycle is already unstalled.
  - exc_valid and br_mispred are ignored while in MEM_WAIT; the sources hold them until acknowledged.
- MD_BUSY:
  - md_start in RUN loads counter = MD_LAT-1 and enters MD_BUSY.
  - While counter != 0: stall IF/ID, ID/EX and EX/MEM; flush MEM/WB to insert a bubble; pc_hold=1; counter decrements each cycle.
  - On counter==0: return to RUN with no stall that cycle.
  - Total stall cycles = MD_LAT-1.
- Exception in RUN or MD_BUSY:
  - Flush all four registers, redirect=1, no stalls.
  - Any MD_BUSY countdown is aborted and the FSM goes to RUN.
- Mispredict in RUN with no exception:
  - Flush IF/ID and ID/EX, redirect=1.
  - If br_slot0=1, also flush_ex_mem=1 with isel_ex_mem=1 (kills slot 1 only).
  - If br_slot0=0, EX/MEM is untouched.
- Load-use in RUN with no exception or mispredict:
  - Stall IF/ID and pc_hold=1.
  - Flush ID/EX to inject a bubble.
  - Exactly one cycle per assertion; ld_use_haz deasserts by construction next cycle.
- Priority, highest first: rst > MEM_WAIT / (mem_req & ~mem_ready) > exc_valid > br_mispred > MD_BUSY > md_start > ld_use_haz.
- Simultaneous events:
  - md_start together with br_mispred: the md op is younger, so it is cancelled; no MD_BUSY entry.
  - md_start together with ld_use_haz: md_start wins, and the load-use bubble is implicit in the MD_BUSY stall.
  - md_start while mem_req & ~mem_ready: the memory wait is taken first, and md_start must be held by the source.
- Counter never wraps: decrement occurs only when counter != 0.

Optional Feature:
- Macro: PIPE_HAZARD_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cyc[31:0] and perf_flush_cnt[31:0].
  - perf_stall_cyc increments every cycle pc_hold=1.
  - perf_flush_cnt increments on every redirect.
  - Both counters saturate at 32'hFFFF_FFFF and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package / Define.v:
  - State encodings: ST_RUN=3'd0, ST_MD_BUSY=3'd1, ST_MEM_WAIT=3'd2.
  - Default MD_LAT.
  - Stage-index constants IF_ID..MEM_WB.
- One natural sub-module, pipe_md_counter: load / decrement / zero-detect counter, reusable for other fixed-latency units.
- FSM and output decode stay in the top module.

Test Plan:
- rst held 3 cycles during MD_BUSY with counter=5 -> after release: state_o=0, all outputs 0, no further stalls.
- md_start pulse with MD_LAT=8 -> stall_if_id/stall_id_ex/stall_ex_mem=1 for exactly 7 cycles, flush_mem_wb=1 in those cycles, back to RUN on cycle 8.
- mem_req=1 with mem_ready=0 for 4 cycles, then 1 -> all stalls=1 for 4 cycles; on cycle 5 all 0 and state RUN.
- br_mispred=1, br_slot0=1 -> same cycle: flush_if_id, flush_id_ex, flush_ex_mem, isel_ex_mem, redirect all 1; with br_slot0=0, flush_ex_mem=0.
- ld_use_haz=1 and br_mispred=1 together -> mispredict response only, stall_if_id=0; ld_use_haz alone -> stall_if_id=1, flush_id_ex=1, pc_hold=1 for one cycle.
- exc_valid=1 at MD_BUSY counter=3 -> all four flushes=1, redirect=1, next cycle state RUN, counter 0.
